fp_adder_pipe: RTL
==================

# fp_adder_pipe

Parametrised, three-stage pipelined IEEE-754-style floating-point adder/subtractor with valid/ready handshakes on both sides. It generalises the combinational single-precision adder to any exponent/mantissa width and adds an explicit add/sub mode, round-to-nearest-even with guard/round/sticky bits, exception flags, and backpressure. It sits between operand-issue logic and a result consumer in the arithmetic datapath.

## Interface
- EXP_W, 8, exponent width (bias = 2^(EXP_W-1)-1)
- MAN_W, 23, stored mantissa width (hidden bit implicit)
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  block accepts operands this cycle
- a, b  in  1+EXP_W+MAN_W each  operands {sign, exp, man}
- sub  in  1  0: a+b, 1: a-b (flips b sign)
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- sum  out  1+EXP_W+MAN_W  result
- flags  out  4  [0] overflow, [1] underflow, [2] invalid, [3] inexact

## Operation
- Stage 1 (align): effective b sign = b.sign^sub. Order operands by {exp,man} magnitude so big >= small. Significands = {1, man, 3'b000} (MAN_W+4 bits). Shift small right by exp difference, saturating at MAN_W+3; shifted-out bits OR into sticky (LSB). Result sign = big sign.
- Stage 2 (add): effective subtract = signs differ. Add or subtract (big - small, never negative) into MAN_W+5 bits including carry.
- Stage 3 (normalise/round): carry set -> shift right 1 (sticky preserved), exp+1. Else leading-zero count, shift left, exp minus count. Round to nearest even on G/R/S; rounding carry-out renormalises (exp+1). Exact cancellation -> +0.
- Exponent arithmetic at EXP_W+2 bits signed. Result exp >= 2^EXP_W-1 -> ±Inf, overflow=1, inexact=1. Result exp <= 0 -> ±0 (flush), underflow=1, inexact=1 when nonzero result lost.
- inexact=1 whenever any of G/R/S was nonzero before rounding.

## Timing
- Latency 3 cycles: operands accepted at edge N appear on sum/out_valid after edge N+3 if not stalled.
- Transfer in when in_valid&in_ready; out when out_valid&out_ready.
- Stall: whole pipeline holds when stage-3 valid and !out_ready. in_ready = !(v3 & !out_ready), combinational from out_ready. Bubbles not compressed; throughput one per cycle without stall.
- sum/flags stable while out_valid & !out_ready.
- Reset: all stage valids 0, out_valid=0, sum=0, flags=0, in_ready=1 after reset release. Reset mid-operation discards in-flight results; no partial result emitted.
- Data registers need not reset; valids must.

## Configuration
- FP_ADDER_SPECIALS_EN defined: exp==0 inputs (zero/denormal) treated as ±0; exp all-ones with man==0 is ±Inf, man!=0 is NaN. Any NaN input or Inf + opposite Inf -> canonical quiet NaN {0, all-ones exp, 1 followed by zeros}, invalid=1. Inf with finite -> that Inf, no flags. 0 + x -> x exactly; (+0)+(-0) -> +0.
- Undefined: every input treated as normalised with hidden 1 regardless of exponent; no NaN/Inf detection; invalid tied 0. Overflow/underflow handling unchanged.

## Test plan
- 0x3F800000 + 0x3F800000, sub=0 -> sum 0x40000000, flags 0, out_valid exactly 3 cycles after acceptance.
- 0x3F800000 with sub=1, b=0x3F800000 -> 0x00000000, flags 0; 0x40400000 - 0x3F800000 -> 0x40000000.
- Rounding: 0x3F800000 + 0x33800000 -> 0x3F800000 (tie to even), inexact=1; 0x3F800000 + 0x34400000 -> 0x3F800002, inexact=1.
- Overflow: 0x7F7FFFFF + 0x7F7FFFFF -> 0x7F800000, overflow=1, inexact=1. With FP_ADDER_SPECIALS_EN: 0x7F800000 + 0xFF800000 -> 0x7FC00000, invalid=1.
- Backpressure: 6 back-to-back ops, out_ready low 4 cycles mid-stream -> in_ready drops same cycle as stall, all 6 results delivered in order, none duplicated, sum held while stalled.
- Assert rst with 2 ops in flight -> out_valid=0 next cycle, no results emitted after release; next op returns correct result in 3 cycles.

Source files
------------

// File: rtl/fp_adder_pipe.sv
// Three-stage pipelined floating-point adder/subtractor with valid/ready handshakes.
// Define FP_ADDER_SPECIALS_EN to enable zero/denormal, Inf and NaN handling.
module fp_adder_pipe #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [EXP_W+MAN_W:0]     a,
  input  logic [EXP_W+MAN_W:0]     b,
  input  logic                     sub,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [EXP_W+MAN_W:0]     sum,
  output logic [3:0]               flags
);
  localparam int unsigned W  = 1 + EXP_W + MAN_W;
  localparam int unsigned SW = MAN_W + 4;
  localparam int unsigned NW = MAN_W + 5;
  localparam int unsigned EW = EXP_W + 2;
  localparam logic [EXP_W-1:0] SH_MAX = EXP_W'(MAN_W + 3);
  localparam logic [EW-1:0]    E_MAX  = EW'((1 << EXP_W) - 1);

  logic adv;
  assign in_ready = !(out_valid && !out_ready);
  assign adv      = in_ready;

  // Stage 1: operand ordering and alignment
  logic             b_sign, a_big, big_sign, eff_sub, lost;
  logic [EXP_W-1:0] big_exp, small_exp, exp_diff, sh;
  logic [MAN_W-1:0] big_man, small_man;
  logic [SW-1:0]    big_sig, small_sig, small_sh, small_al;

  always_comb begin
    b_sign    = b[W-1] ^ sub;
    a_big     = a[W-2:0] >= b[W-2:0];
    big_sign  = a_big ? a[W-1] : b_sign;
    eff_sub   = a[W-1] ^ b_sign;
    big_exp   = a_big ? a[W-2:MAN_W] : b[W-2:MAN_W];
    small_exp = a_big ? b[W-2:MAN_W] : a[W-2:MAN_W];
    big_man   = a_big ? a[MAN_W-1:0] : b[MAN_W-1:0];
    small_man = a_big ? b[MAN_W-1:0] : a[MAN_W-1:0];
    exp_diff  = big_exp - small_exp;
    sh        = (exp_diff > SH_MAX) ? SH_MAX : exp_diff;
    big_sig   = {1'b1, big_man, 3'b000};
    small_sig = {1'b1, small_man, 3'b000};
    small_sh  = small_sig >> sh;
    lost      = |(small_sig & ~({SW{1'b1}} << sh));
    small_al  = {small_sh[SW-1:1], small_sh[0] | lost};
  end

  logic         spec_hit;
  logic [W-1:0] spec_res;
  logic [3:0]   spec_fl;

`ifdef FP_ADDER_SPECIALS_EN
  logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  always_comb begin
    a_zero   = a[W-2:MAN_W] == '0;
    b_zero   = b[W-2:MAN_W] == '0;
    a_inf    = (a[W-2:MAN_W] == {EXP_W{1'b1}}) && (a[MAN_W-1:0] == '0);
    b_inf    = (b[W-2:MAN_W] == {EXP_W{1'b1}}) && (b[MAN_W-1:0] == '0);
    a_nan    = (a[W-2:MAN_W] == {EXP_W{1'b1}}) && (a[MAN_W-1:0] != '0);
    b_nan    = (b[W-2:MAN_W] == {EXP_W{1'b1}}) && (b[MAN_W-1:0] != '0);
    spec_hit = 1'b1;
    spec_res = '0;
    spec_fl  = '0;
    if (a_nan || b_nan || (a_inf && b_inf && (a[W-1] != b_sign))) begin
      spec_res = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
      spec_fl  = 4'b0100;
    end else if (a_inf) begin
      spec_res = a;
    end else if (b_inf) begin
      spec_res = {b_sign, b[W-2:0]};
    end else if (a_zero && b_zero) begin
      // Only -0 + -0 keeps the negative sign
      spec_res = {a[W-1] & b_sign, {(W-1){1'b0}}};
    end else if (a_zero) begin
      spec_res = {b_sign, b[W-2:0]};
    end else if (b_zero) begin
      spec_res = a;
    end else begin
      spec_hit = 1'b0;
    end
  end
`else
  assign spec_hit = 1'b0;
  assign spec_res = '0;
  assign spec_fl  = '0;
`endif

  logic             v1_q, v2_q;
  logic             sign1_q, sub1_q, spec1_q, sign2_q, spec2_q;
  logic [EXP_W-1:0] exp1_q, exp2_q;
  logic [SW-1:0]    big1_q, small1_q;
  logic [NW-1:0]    sum2_q;
  logic [W-1:0]     spec_res1_q, spec_res2_q;
  logic [3:0]       spec_fl1_q, spec_fl2_q;

  always_ff @(posedge clk) begin
    if (adv) begin
      sign1_q     <= big_sign;
      sub1_q      <= eff_sub;
      exp1_q      <= big_exp;
      big1_q      <= big_sig;
      small1_q    <= small_al;
      spec1_q     <= spec_hit;
      spec_res1_q <= spec_res;
      spec_fl1_q  <= spec_fl;
      sign2_q     <= sign1_q;
      exp2_q      <= exp1_q;
      sum2_q      <= sub1_q ? ({1'b0, big1_q} - {1'b0, small1_q})
                            : ({1'b0, big1_q} + {1'b0, small1_q});
      spec2_q     <= spec1_q;
      spec_res2_q <= spec_res1_q;
      spec_fl2_q  <= spec_fl1_q;
    end
  end

  // Stage 3: normalise, round, classify
  logic [EW-1:0] lzc, e_n, e_r;
  logic [NW-2:0] norm;
  logic [MAN_W:0] mant;
  logic          rnd_up, inex;
  logic [W-1:0]  res;
  logic [3:0]    res_fl;

  always_comb begin
    lzc = '0;
    for (int i = 0; i < NW - 1; i++) begin
      if (sum2_q[i]) lzc = EW'(NW - 2 - i);
    end
    if (sum2_q[NW-1]) begin
      norm = {sum2_q[NW-1:2], sum2_q[1] | sum2_q[0]};
      e_n  = {2'b00, exp2_q} + {{(EW-1){1'b0}}, 1'b1};
    end else begin
      norm = sum2_q[NW-2:0] << lzc;
      e_n  = {2'b00, exp2_q} - lzc;
    end
    rnd_up = norm[2] & (norm[1] | norm[0] | norm[3]);
    mant   = {1'b0, norm[NW-3:3]} + {{MAN_W{1'b0}}, rnd_up};
    e_r    = mant[MAN_W] ? e_n + {{(EW-1){1'b0}}, 1'b1} : e_n;
    inex   = |norm[2:0];
    res    = '0;
    res_fl = '0;
    if (spec2_q) begin
      res    = spec_res2_q;
      res_fl = spec_fl2_q;
    end else if (!norm[NW-2]) begin
      res = '0;
    end else if (!e_r[EW-1] && (e_r >= E_MAX)) begin
      res    = {sign2_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      res_fl = 4'b1001;
    end else if (e_r[EW-1] || (e_r == '0)) begin
      res    = {sign2_q, {(W-1){1'b0}}};
      res_fl = 4'b1010;
    end else begin
      res    = {sign2_q, e_r[EXP_W-1:0], mant[MAN_W-1:0]};
      res_fl = {inex, 3'b000};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q      <= 1'b0;
      v2_q      <= 1'b0;
      out_valid <= 1'b0;
      sum       <= '0;
      flags     <= '0;
    end else if (adv) begin
      v1_q      <= in_valid;
      v2_q      <= v1_q;
      out_valid <= v2_q;
      if (v2_q) begin
        sum   <= res;
        flags <= res_fl;
      end
    end
  end
endmodule
